vram_byte_port: RTL and testbench

Host-side byte access port into video RAM. Holds a 17-bit byte address with a programmable auto-increment and turns 8-bit host reads/writes into 32-bit word transactions with byte selects on the VRAM slave bus. Sits between the host register file and the VRAM bus arbiter, acting as the initiator on that bus. A read prefetch keeps the byte at the current address available with zero host-visible latency.

---
 rtl/vram_byte_port.sv | 152 +++++++++++++++
 tb/tb_vram_byte_port.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_byte_port.sv
// Host byte port into 32-bit VRAM: auto-incrementing byte address, lane-select writes, read prefetch.
// Optional macro VRAM_PORT_DECR_EN enables the subtract direction selected by host_decr.
module vram_byte_port (
    input  logic        clk,
    input  logic        rst,
    input  logic        host_addr_wr,
    input  logic [16:0] host_addr,
    input  logic [3:0]  host_incr_sel,
    input  logic        host_decr,
    input  logic        host_data_wr,
    input  logic [7:0]  host_wrdata,
    input  logic        host_data_rd,
    output logic [7:0]  host_rddata,
    output logic        host_busy,
    output logic        bus_strobe,
    input  logic        bus_ack,
    output logic [14:0] bus_addr,
    output logic [31:0] bus_wrdata,
    output logic [3:0]  bus_wrbytesel,
    output logic        bus_write,
    input  logic [31:0] bus_rddata
);

    typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ, RD_WAIT} state_t;

    state_t      state_q;
    logic [16:0] addr_q;
    logic [9:0]  incr_q;
    logic [7:0]  rddata_q;
    logic        busy_q;
    logic        strobe_q;
    logic        write_q;
    logic [14:0] bus_addr_q;
    logic [31:0] wrdata_q;
    logic [3:0]  bytesel_q;
    logic [16:0] addr_d;
    logic [7:0]  lane_byte;

    // Codes 1..10 are powers of two; 11..15 step by text-row widths.
    function automatic logic [9:0] decode_incr(input logic [3:0] sel);
        case (sel)
            4'd0:    return 10'd0;
            4'd11:   return 10'd40;
            4'd12:   return 10'd80;
            4'd13:   return 10'd160;
            4'd14:   return 10'd320;
            4'd15:   return 10'd640;
            default: return 10'd1 << (sel - 4'd1);
        endcase
    endfunction

`ifdef VRAM_PORT_DECR_EN
    logic decr_q;
    always_comb addr_d = decr_q ? (addr_q - {7'd0, incr_q}) : (addr_q + {7'd0, incr_q});
`else
    logic unused_host_decr;
    assign unused_host_decr = host_decr;
    always_comb addr_d = addr_q + {7'd0, incr_q};
`endif

    always_comb begin
        lane_byte = bus_rddata[7:0];
        case (addr_q[1:0])
            2'd0: lane_byte = bus_rddata[7:0];
            2'd1: lane_byte = bus_rddata[15:8];
            2'd2: lane_byte = bus_rddata[23:16];
            2'd3: lane_byte = bus_rddata[31:24];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            incr_q     <= '0;
            rddata_q   <= '0;
            busy_q     <= 1'b0;
            strobe_q   <= 1'b0;
            write_q    <= 1'b0;
            bus_addr_q <= '0;
            wrdata_q   <= '0;
            bytesel_q  <= '0;
`ifdef VRAM_PORT_DECR_EN
            decr_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (host_addr_wr) begin
                        addr_q     <= host_addr;
                        incr_q     <= decode_incr(host_incr_sel);
`ifdef VRAM_PORT_DECR_EN
                        decr_q     <= host_decr;
`endif
                        bus_addr_q <= host_addr[16:2];
                        strobe_q   <= 1'b1;
                        write_q    <= 1'b0;
                        bytesel_q  <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= RD_REQ;
                    end else if (host_data_wr) begin
                        wrdata_q   <= {4{host_wrdata}};
                        bus_addr_q <= addr_q[16:2];
                        strobe_q   <= 1'b1;
                        write_q    <= 1'b1;
                        bytesel_q  <= 4'b0001 << addr_q[1:0];
                        busy_q     <= 1'b1;
                        state_q    <= WR_REQ;
                    end else if (host_data_rd) begin
                        addr_q     <= addr_d;
                        bus_addr_q <= addr_d[16:2];
                        strobe_q   <= 1'b1;
                        write_q    <= 1'b0;
                        bytesel_q  <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= RD_REQ;
                    end
                end
                // Strobe stays high straight into the follow-up prefetch of the advanced address.
                WR_REQ: begin
                    if (bus_ack) begin
                        addr_q     <= addr_d;
                        bus_addr_q <= addr_d[16:2];
                        write_q    <= 1'b0;
                        bytesel_q  <= '0;
                        state_q    <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (bus_ack) begin
                        strobe_q <= 1'b0;
                        state_q  <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    rddata_q <= lane_byte;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign host_rddata   = rddata_q;
    assign host_busy     = busy_q;
    assign bus_strobe    = strobe_q;
    assign bus_write     = write_q;
    assign bus_addr      = bus_addr_q;
    assign bus_wrdata    = wrdata_q;
    assign bus_wrbytesel = bytesel_q;

endmodule

// File: tb/tb_vram_byte_port.sv
// Directed bench for vram_byte_port: bus transactions scoreboarded against a queue, prefetch bytes
// checked against a local VRAM image. Define VRAM_PORT_DECR_EN for both files to cover subtract mode.
module tb_vram_byte_port;

    logic        clk;
    logic        rst;
    logic        host_addr_wr;
    logic [16:0] host_addr;
    logic [3:0]  host_incr_sel;
    logic        host_decr;
    logic        host_data_wr;
    logic [7:0]  host_wrdata;
    logic        host_data_rd;
    logic [7:0]  host_rddata;
    logic        host_busy;
    logic        bus_strobe;
    logic        bus_ack;
    logic [14:0] bus_addr;
    logic [31:0] bus_wrdata;
    logic [3:0]  bus_wrbytesel;
    logic        bus_write;
    logic [31:0] bus_rddata;

`ifdef VRAM_PORT_DECR_EN
    localparam bit DECR_EN = 1'b1;
`else
    localparam bit DECR_EN = 1'b0;
`endif

    vram_byte_port dut (
        .clk(clk), .rst(rst),
        .host_addr_wr(host_addr_wr), .host_addr(host_addr),
        .host_incr_sel(host_incr_sel), .host_decr(host_decr),
        .host_data_wr(host_data_wr), .host_wrdata(host_wrdata),
        .host_data_rd(host_data_rd), .host_rddata(host_rddata),
        .host_busy(host_busy), .bus_strobe(bus_strobe), .bus_ack(bus_ack),
        .bus_addr(bus_addr), .bus_wrdata(bus_wrdata), .bus_wrbytesel(bus_wrbytesel),
        .bus_write(bus_write), .bus_rddata(bus_rddata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:32767];
    logic [51:0] exp_q [$];
    logic [9:0]  incr_tab [16] = '{10'd0, 10'd1, 10'd2, 10'd4, 10'd8, 10'd16, 10'd32, 10'd64,
                                   10'd128, 10'd256, 10'd512, 10'd40, 10'd80, 10'd160, 10'd320, 10'd640};
    logic [16:0] exp_addr;
    logic [9:0]  exp_incr;
    logic        exp_decr;
    logic [7:0]  exp_rd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] byte_at(input logic [16:0] a);
        return 8'(mem[a[16:2]] >> (8 * a[1:0]));
    endfunction

    function automatic logic [16:0] adv(input logic [16:0] a);
        if (DECR_EN && exp_decr) return a - {7'd0, exp_incr};
        return a + {7'd0, exp_incr};
    endfunction

    // Bus slave: read data appears the cycle after the accepted read.
    always @(posedge clk)
        if (bus_strobe === 1'b1 && bus_ack === 1'b1 && bus_write === 1'b0)
            bus_rddata <= mem[bus_addr];

    // Scoreboard: every accepted transaction must match the oldest expectation.
    always @(negedge clk) begin
        #1;
        if (bus_strobe === 1'b1 && bus_ack === 1'b1) begin
            if (exp_q.size() == 0)
                chk("bus_txn_expected", 64'(exp_q.size()), 64'd1);
            else
                chk("bus_txn", 64'({bus_addr, bus_write, bus_wrbytesel, bus_write ? bus_wrdata : 32'h0}),
                    64'(exp_q.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load_pulse(input logic [16:0] a, input logic [3:0] sel, input logic d);
        host_addr = a; host_incr_sel = sel; host_decr = d; host_addr_wr = 1'b1;
        exp_addr = a; exp_incr = incr_tab[sel]; exp_decr = d;
        exp_q.push_back({a[16:2], 1'b0, 4'b0000, 32'h0});
        tick();
        host_addr_wr = 1'b0;
    endtask

    task automatic write_pulse(input logic [7:0] b);
        logic [4:0] sh;
        sh = {exp_addr[1:0], 3'b000};
        host_wrdata = b; host_data_wr = 1'b1;
        exp_q.push_back({exp_addr[16:2], 1'b1, 4'b0001 << exp_addr[1:0], {4{b}}});
        mem[exp_addr[16:2]] = (mem[exp_addr[16:2]] & ~(32'hFF << sh)) | (32'(b) << sh);
        exp_addr = adv(exp_addr);
        exp_q.push_back({exp_addr[16:2], 1'b0, 4'b0000, 32'h0});
        tick();
        host_data_wr = 1'b0;
    endtask

    task automatic read_pulse(input string tag);
        chk({tag, "_rd_same_cycle"}, 64'(host_rddata), 64'(exp_rd));
        host_data_rd = 1'b1;
        exp_addr = adv(exp_addr);
        exp_q.push_back({exp_addr[16:2], 1'b0, 4'b0000, 32'h0});
        tick();
        host_data_rd = 1'b0;
    endtask

    task automatic finish_op(input string tag);
        int unsigned n;
        n = 0;
        while (host_busy !== 1'b0 && n < 20) begin tick(); n++; end
        chk({tag, "_idle"}, 64'(host_busy), 64'd0);
        exp_rd = byte_at(exp_addr);
        chk({tag, "_prefetch"}, 64'(host_rddata), 64'(exp_rd));
    endtask

    initial begin
        for (int unsigned i = 0; i < 32768; i++) mem[i] = (i + 1) * 32'h9E37_79B1;
        mem[1] = 32'h4433_2211;
        rst = 1'b1; host_addr_wr = 1'b0; host_addr = '0; host_incr_sel = '0; host_decr = 1'b0;
        host_data_wr = 1'b0; host_wrdata = '0; host_data_rd = 1'b0; bus_ack = 1'b1; bus_rddata = '0;
        exp_addr = '0; exp_incr = '0; exp_decr = 1'b0; exp_rd = '0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("reset_outputs", 64'({host_rddata, host_busy, bus_strobe, bus_write, bus_addr, bus_wrbytesel, bus_wrdata}), 64'd0);
        tick();
        chk("reset_no_prefetch", 64'(bus_strobe), 64'd0);

        // Load 0x00005 +1: strobe N+1, capture end N+2, busy low N+3.
        load_pulse(17'h00005, 4'd1, 1'b0);
        chk("load_n1", 64'({host_busy, bus_strobe, bus_write, bus_addr, bus_wrbytesel}), 64'({2'b11, 1'b0, 15'h0001, 4'b0}));
        tick();
        chk("load_n2", 64'({host_busy, bus_strobe}), 64'b10);
        tick();
        chk("load_n3_busy", 64'(host_busy), 64'd0);
        chk("load_n3_byte", 64'(host_rddata), 64'h22);
        exp_rd = 8'h22;

        // Write 0xAB at 0x00006: write strobe N+1, read strobe N+2, busy low N+4.
        load_pulse(17'h00006, 4'd1, 1'b0);
        finish_op("load6");
        write_pulse(8'hAB);
        chk("wr_n1", 64'({bus_strobe, bus_write, bus_addr, bus_wrbytesel, bus_wrdata}),
            64'({1'b1, 1'b1, 15'h0001, 4'b0100, 32'hABAB_ABAB}));
        tick();
        chk("wr_n2", 64'({bus_strobe, bus_write, bus_addr, bus_wrbytesel}), 64'({1'b1, 1'b0, 15'h0001, 4'b0000}));
        tick();
        chk("wr_n3", 64'({host_busy, bus_strobe}), 64'b10);
        tick();
        chk("wr_n4_busy", 64'(host_busy), 64'd0);
        chk("wr_n4_byte", 64'(host_rddata), 64'h44);
        exp_rd = byte_at(exp_addr);

        // Address wrap at the top of the 128 KiB space.
        load_pulse(17'h1FFFF, 4'd1, 1'b0);
        finish_op("load_top");
        read_pulse("wrap");
        finish_op("wrap");
        chk("wrap_addr", 64'(exp_addr), 64'd0);

        // +40 stepping, then the direction bit.
        load_pulse(17'h00000, 4'd11, 1'b0);
        finish_op("step40_load");
        for (int k = 0; k < 3; k++) begin
            read_pulse("step40");
            finish_op("step40");
        end
        chk("step40_final", 64'(exp_addr), 64'd120);
        load_pulse(17'd120, 4'd11, 1'b1);
        finish_op("decr_load");
        read_pulse("decr");
        finish_op("decr");
        chk("decr_addr", 64'(exp_addr), DECR_EN ? 64'd80 : 64'd160);

        // Every increment code.
        for (int s = 0; s < 16; s++) begin
            load_pulse(17'h00100, 4'(s), 1'b0);
            finish_op("sel_load");
            read_pulse("sel");
            finish_op("sel");
        end

        // Stall the write for 5 cycles; host pulses meanwhile must be ignored.
        load_pulse(17'h00010, 4'd2, 1'b0);
        finish_op("stall_load");
        bus_ack = 1'b0;
        write_pulse(8'h5A);
        for (int i = 0; i < 5; i++) begin
            chk("stall_hold", 64'({host_busy, bus_strobe, bus_write, bus_addr, bus_wrbytesel, bus_wrdata}),
                64'({1'b1, 1'b1, 1'b1, 15'h0004, 4'b0001, 32'h5A5A_5A5A}));
            host_data_wr = (i == 1); host_wrdata = 8'hFF;
            host_addr_wr = (i == 1); host_addr = 17'h1F000; host_incr_sel = 4'd15;
            tick();
        end
        host_data_wr = 1'b0; host_addr_wr = 1'b0;
        bus_ack = 1'b1;
        finish_op("stall");
        read_pulse("stall_after");
        finish_op("stall_after");

        // Simultaneous load and write: only the load happens.
        host_wrdata = 8'hEE; host_data_wr = 1'b1; host_data_rd = 1'b1;
        load_pulse(17'h00100, 4'd1, 1'b0);
        host_data_wr = 1'b0; host_data_rd = 1'b0;
        finish_op("priority");

        // Reset while the prefetch request is pending.
        bus_ack = 1'b0;
        load_pulse(17'h00200, 4'd1, 1'b0);
        tick();
        chk("rst_pre", 64'(bus_strobe), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid", 64'({host_rddata, host_busy, bus_strobe, bus_write, bus_addr, bus_wrbytesel, bus_wrdata}), 64'd0);
        void'(exp_q.pop_back());
        bus_ack = 1'b1;
        exp_addr = '0; exp_incr = '0; exp_decr = 1'b0; exp_rd = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_quiet", 64'({host_busy, bus_strobe}), 64'd0);
        end
        read_pulse("post_rst");
        finish_op("post_rst");
        load_pulse(17'h00005, 4'd1, 1'b0);
        finish_op("post_rst_load");

        repeat (3) tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
